// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the PCIe transmit-queue arbiter.
package pcie_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam int          STALL_W   = 16;
  localparam logic [15:0] ABORT_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == ABORT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcie_tx_arb_if.sv
// Requester-side and queue-side beat handshake of the transmit arbiter.
interface pcie_tx_arb_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]       in_v;
  logic [NUM_PORTS*WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]       in_last;
  logic [NUM_PORTS-1:0]       in_grant;
  logic                       req_v;
  logic [WIDTH-1:0]           req_data;
  logic                       req_grant;

  // master: the arbiter, which drives the queue enqueue port
  modport master (
    input  in_v, in_data, in_last, req_grant,
    output in_grant, req_v, req_data
  );

  // slave: DMA engines plus queue, i.e. everything around the arbiter
  modport slave (
    output in_v, in_data, in_last, req_grant,
    input  in_grant, req_v, req_data
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PB = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PB-1:0] ptr,
  output logic [PB-1:0] winner,
  output logic          any_req
);

  int idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        winner  = PB'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arb.sv
// Round-robin arbiter locking one DMA requester onto the transmit queue for a whole TLP.
module pcie_tx_arb
  import pcie_tx_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  pcie_tx_arb_if.master        bus,
  output logic                 busy,
  output logic [PORT_BITS-1:0] cur_port,
  output logic                 abort_pulse,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          abort_cnt
);

  arb_state_e           state_q, state_d;
  logic [PORT_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_BITS-1:0] cur_q, cur_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [31:0]          pkt_q, pkt_d;
  logic [15:0]          abort_cnt_q, abort_cnt_d;
  logic                 abort_pulse_q, abort_pulse_d;

  logic [PORT_BITS-1:0] winner;
  logic                 any_req;
  logic                 cur_v;
  logic                 cur_last;
  logic                 expire;
  logic [PORT_BITS-1:0] next_port;

  rr_pick #(.N(NUM_PORTS), .PB(PORT_BITS)) u_pick (
    .req     (bus.in_v),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign cur_v     = bus.in_v[cur_q];
  assign cur_last  = bus.in_last[cur_q];
  // Explicit wrap: NUM_PORTS need not be a power of two.
  assign next_port = (int'(cur_q) == NUM_PORTS - 1) ? '0 : cur_q + PORT_BITS'(1);
  assign expire    = (TIMEOUT != 0) && (stall_q == STALL_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_d         = cur_q;
    stall_d       = stall_q;
    pkt_d         = pkt_q;
    abort_cnt_d   = abort_cnt_q;
    abort_pulse_d = 1'b0;
    bus.req_v     = 1'b0;
    bus.req_data  = '0;
    bus.in_grant  = '0;

    case (state_q)
      ARB_IDLE: begin
        // Arbitration cycle: no beat moves, giving one bubble per TLP.
        if (any_req) begin
          cur_d   = winner;
          stall_d = '0;
          state_d = ARB_LOCKED;
        end
      end

      ARB_LOCKED: begin
        bus.req_v           = cur_v;
        bus.req_data        = bus.in_data[int'(cur_q)*WIDTH +: WIDTH];
        bus.in_grant[cur_q] = bus.req_grant & cur_v;

        if (cur_v && bus.req_grant) begin
          stall_d = '0;
          if (cur_last) begin
            pkt_d    = pkt_q + 32'd1;
            rr_ptr_d = next_port;
            state_d  = ARB_IDLE;
          end
        end else if (!cur_v) begin
          // Only a silent requester ages the watchdog; queue backpressure holds it.
          if (expire) begin
            abort_pulse_d = 1'b1;
            abort_cnt_d   = sat_inc16(abort_cnt_q);
            rr_ptr_d      = next_port;
            stall_d       = '0;
            state_d       = ARB_IDLE;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      cur_q         <= '0;
      stall_q       <= '0;
      pkt_q         <= '0;
      abort_cnt_q   <= '0;
      abort_pulse_q <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_q         <= cur_d;
      stall_q       <= stall_d;
      pkt_q         <= pkt_d;
      abort_cnt_q   <= abort_cnt_d;
      abort_pulse_q <= abort_pulse_d;
    end
  end

  assign busy        = (state_q == ARB_LOCKED);
  assign cur_port    = cur_q;
  assign abort_pulse = abort_pulse_q;
  assign pkt_cnt     = pkt_q;
  assign abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Randomized and directed bench for pcie_tx_arb against a transaction-level reference model.
module tb_pcie_tx_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, abort_pulse;
  logic [1:0]  cur_port;
  logic [31:0] pkt_cnt;
  logic [15:0] abort_cnt;

  logic        busy3, abort_pulse3;
  logic [1:0]  cur_port3;
  logic [31:0] pkt_cnt3;
  logic [15:0] abort_cnt3;

  always #5 clk = ~clk;

  pcie_tx_arb_if #(.WIDTH(W), .NUM_PORTS(N)) bus ();
  pcie_tx_arb_if #(.WIDTH(W), .NUM_PORTS(3)) bus3 ();

  pcie_tx_arb #(.WIDTH(W), .NUM_PORTS(N), .PORT_BITS(2), .TIMEOUT(TO)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .cur_port    (cur_port),
    .abort_pulse (abort_pulse),
    .pkt_cnt     (pkt_cnt),
    .abort_cnt   (abort_cnt)
  );

  pcie_tx_arb #(.WIDTH(W), .NUM_PORTS(3), .PORT_BITS(2), .TIMEOUT(16)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus3),
    .busy        (busy3),
    .cur_port    (cur_port3),
    .abort_pulse (abort_pulse3),
    .pkt_cnt     (pkt_cnt3),
    .abort_cnt   (abort_cnt3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Requester BFMs: per-port queue of TLP lengths (head = beats left in current TLP).
  int tlp_q[N][$];
  int seq[N];
  bit silent[N];
  int v_pct, g_pct;

  // Reference model, expressed as arbitration events rather than RTL state.
  bit          m_locked;
  int          m_owner, m_ptr, m_stall, m_abort;
  logic [31:0] m_pkt;
  bit          m_pulse;

  // Observed statistics for directed expectations.
  int gcnt[N];
  int last_acc[N];
  int done_log[$];
  int pulse_cnt, pulse_cyc, cyc;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_stall = 0;
    m_pkt = '0; m_abort = 0; m_pulse = 0;
    for (int p = 0; p < N; p++) begin
      tlp_q[p].delete();
      silent[p] = 0;
    end
  endtask

  task automatic clear_stats();
    for (int p = 0; p < N; p++) gcnt[p] = 0;
    done_log.delete();
    pulse_cnt = 0;
  endtask

  task automatic load(input int p, input int len);
    tlp_q[p].push_back(len);
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      if (tlp_q[p].size() > 0 && !silent[p] && int'($urandom % 100) < v_pct) begin
        bus.in_v[p]             = 1'b1;
        bus.in_data[p*W +: W]   = {8'(p), 24'(seq[p])};
        bus.in_last[p]          = (tlp_q[p][0] == 1);
      end else begin
        bus.in_v[p]             = 1'b0;
        bus.in_data[p*W +: W]   = $urandom;
        bus.in_last[p]          = 1'(($urandom % 2));
      end
    end
    bus.req_grant = (int'($urandom % 100) < g_pct);
  endtask

  // One clock: drive after the rising edge, check on the falling edge, advance the model.
  task automatic cycle();
    bit          ev;
    logic [3:0]  eg;
    logic [31:0] ed;
    int          win;
    drive_inputs();
    @(negedge clk);
    ev = m_locked && bus.in_v[m_owner];
    eg = (ev && bus.req_grant) ? 4'(1 << m_owner) : 4'b0;
    ed = m_locked ? bus.in_data[m_owner*W +: W] : 32'd0;
    check("busy", busy, m_locked);
    check("cur_port", cur_port, m_owner);
    check("req_v", bus.req_v, ev);
    check("req_data", bus.req_data, ed);
    check("in_grant", bus.in_grant, eg);
    check("pkt_cnt", pkt_cnt, m_pkt);
    check("abort_cnt", abort_cnt, m_abort);
    check("abort_pulse", abort_pulse, m_pulse);

    for (int p = 0; p < N; p++) begin
      if (bus.in_grant[p]) begin
        gcnt[p]++;
        last_acc[p] = cyc;
        if (bus.in_last[p]) done_log.push_back(p);
      end
    end
    if (abort_pulse) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end

    m_pulse = 0;
    if (!m_locked) begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && bus.in_v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
        m_locked = 1; m_owner = win; m_stall = 0;
      end
    end else if (ev && bus.req_grant) begin
      m_stall = 0;
      seq[m_owner]++;
      tlp_q[m_owner][0] = tlp_q[m_owner][0] - 1;
      if (tlp_q[m_owner][0] == 0) void'(tlp_q[m_owner].pop_front());
      if (bus.in_last[m_owner]) begin
        m_pkt++;
        m_ptr = (m_owner + 1) % N;
        m_locked = 0;
      end
    end else if (!ev) begin
      if (m_stall == TO - 1) begin
        m_pulse = 1;
        if (m_abort < 65535) m_abort++;
        m_ptr = (m_owner + 1) % N;
        m_locked = 0;
      end else begin
        m_stall++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  int exp_ord[4] = '{0, 1, 0, 1};
  int acc1, pending, guard;

  initial begin
    rst = 1'b1;
    bus.in_v = '0; bus.in_data = '0; bus.in_last = '0; bus.req_grant = 1'b0;
    bus3.in_v = '0; bus3.in_data = '0; bus3.in_last = '0; bus3.req_grant = 1'b0;
    for (int p = 0; p < N; p++) seq[p] = 0;
    cyc = 0;
    model_reset();
    clear_stats();
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_v", bus.req_v, 0);
    check("rst_req_data", bus.req_data, 0);
    check("rst_in_grant", bus.in_grant, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_abort", abort_cnt, 0);
    check("rst_pulse", abort_pulse, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single port, 3-beat TLP, queue always ready.
    v_pct = 100; g_pct = 100;
    load(2, 3);
    repeat (6) cycle();
    check("t1_beats_p2", gcnt[2], 3);
    check("t1_pkt", pkt_cnt, 1);

    // Two always-valid ports alternate whole TLPs.
    clear_stats();
    load(0, 2); load(0, 2); load(1, 2); load(1, 2);
    repeat (14) cycle();
    check("t2_tlps", done_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < done_log.size()) check($sformatf("t2_order%0d", i), done_log[i], exp_ord[i]);

    // Long queue backpressure with valid held is not a stall.
    clear_stats();
    g_pct = 0;
    load(3, 2);
    repeat (1000) cycle();
    check("t3_no_abort", pulse_cnt, 0);
    check("t3_no_beats", gcnt[3], 0);
    g_pct = 100;
    repeat (5) cycle();
    check("t3_resumed", gcnt[3], 2);

    // Requester 1 goes silent after one beat; watchdog must release it.
    clear_stats();
    load(1, 2);
    guard = 0;
    while (gcnt[1] == 0 && guard < 10) begin
      cycle();
      guard++;
    end
    check("t4_first_beat", gcnt[1], 1);
    acc1 = last_acc[1];
    silent[1] = 1;
    load(0, 1); load(2, 1);
    repeat (270) cycle();
    check("t4_pulse_once", pulse_cnt, 1);
    // Pulse is visible in the cycle after the 256th edge following the accepting edge.
    check("t4_pulse_time", pulse_cyc - acc1, 257);
    check("t4_abort_cnt", abort_cnt, 1);
    check("t4_next_winner", (done_log.size() > 0) ? done_log[0] : -1, 2);
    silent[1] = 0;
    tlp_q[1].delete();

    // Randomized traffic.
    v_pct = 80; g_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++)
        if (tlp_q[p].size() == 0 && $urandom % 8 == 0) load(p, 1 + int'($urandom % 4));
      cycle();
    end
    v_pct = 100; g_pct = 100;
    guard = 0;
    pending = 1;
    while (pending != 0 && guard < 400) begin
      cycle();
      guard++;
      pending = 0;
      for (int p = 0; p < N; p++) pending += tlp_q[p].size();
    end
    check("drain", pending, 0);
    repeat (2) cycle();

    // Async reset on beat 2 of a 4-beat TLP.
    clear_stats();
    load(0, 4);
    guard = 0;
    while (gcnt[0] < 1 && guard < 10) begin
      cycle();
      guard++;
    end
    check("t6_beat1", gcnt[0], 1);
    drive_inputs();
    #2 rst = 1'b1;
    #1;
    check("t6_req_v", bus.req_v, 0);
    check("t6_req_data", bus.req_data, 0);
    check("t6_in_grant", bus.in_grant, 0);
    check("t6_busy", busy, 0);
    check("t6_pkt", pkt_cnt, 0);
    check("t6_abort", abort_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    check("t6_pkt_after", pkt_cnt, 0);

    // Three-port instance: pointer wraps to 0 after port 2 completes.
    bus3.in_v = 3'b100; bus3.in_last = 3'b100; bus3.req_grant = 1'b1;
    @(negedge clk);
    check("t5_arb_busy", busy3, 0);
    @(negedge clk);
    check("t5_lock_busy", busy3, 1);
    check("t5_lock_port", cur_port3, 2);
    check("t5_grant", bus3.in_grant, 3'b100);
    @(posedge clk);
    #1 bus3.in_v = 3'b101; bus3.in_last = 3'b101;
    @(negedge clk);
    check("t5_idle", busy3, 0);
    check("t5_pkt", pkt_cnt3, 1);
    @(negedge clk);
    check("t5_wrap_winner", cur_port3, 0);
    check("t5_wrap_grant", bus3.in_grant, 3'b001);
    @(posedge clk);
    #1 bus3.in_v = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
